// File: rtl/bias_add_requant_pkg.sv
// bias_add_requant_pkg
//   Shared definitions for the bias-add / requantisation block:
//   FSM state encoding, the requant shift width and the widening rule for
//   the bias-add sum (one bit wider than the wider operand so the add can
//   never overflow).
package bias_add_requant_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SHIFT_W = 5;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int SUM_W = max_w(32, 32) + 1;

endpackage

// File: rtl/bias_lane_requant.sv
// bias_lane_requant
//   One output lane: registered bias add, then rounding arithmetic right
//   shift, signed saturation to OUT_W bits and (optionally) ReLU, registered
//   into out_q.
//   Optional build macro: BIAS_ADD_RELU_EN -- negative results are forced
//   to 0 and a clamp towards the negative rail no longer reports saturation.
// Ports:
//   clk, rst   clock, async active-low reset
//   add_en     load the sum register from pe + bias
//   out_en     load out_q from the requantised sum register
//   pe, bias   signed lane operands
//   shift      requant right-shift amount (0..31)
//   out_q      registered OUT_W-bit result (holds when out_en is low)
//   sat        combinational: current sum register clamps at the output
module bias_lane_requant
  import bias_add_requant_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int BIAS_W = 32,
  parameter int OUT_W  = 8,
  parameter int SUM_W  = max_w(ACC_W, BIAS_W) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     add_en,
  input  logic                     out_en,
  input  logic signed [ACC_W-1:0]  pe,
  input  logic signed [BIAS_W-1:0] bias,
  input  logic [SHIFT_W-1:0]       shift,
  output logic [OUT_W-1:0]         out_q,
  output logic                     sat
);

  // One extra bit so adding the rounding constant to an extreme sum cannot wrap.
  localparam int RND_W = SUM_W + 1;

  localparam logic signed [RND_W-1:0] MAX_V = RND_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [RND_W-1:0] MIN_V = RND_W'(-(2 ** (OUT_W - 1)));
  localparam logic [OUT_W-1:0] MAX_O = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_O = {1'b1, {(OUT_W - 1){1'b0}}};

  logic signed [SUM_W-1:0] sum_q;
  logic signed [RND_W-1:0] ext;
  logic signed [RND_W-1:0] rnd_add;
  logic signed [RND_W-1:0] rounded;
  logic signed [RND_W-1:0] shifted;
  logic                    hi;
  logic                    lo;
  logic [OUT_W-1:0]        clamped;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else if (add_en) begin
      sum_q <= SUM_W'(pe) + SUM_W'(bias);
    end
  end

  always_comb begin
    ext     = RND_W'(sum_q);
    rnd_add = '0;
    if (shift != '0) begin
      rnd_add = RND_W'(1) << (shift - SHIFT_W'(1));
    end
    rounded = ext + rnd_add;
    shifted = rounded >>> shift;
    hi      = (shifted > MAX_V);
    lo      = (shifted < MIN_V);
    clamped = shifted[OUT_W-1:0];
    if (hi) begin
      clamped = MAX_O;
    end else if (lo) begin
      clamped = MIN_O;
    end
`ifdef BIAS_ADD_RELU_EN
    if (clamped[OUT_W-1]) begin
      clamped = '0;
    end
    sat = hi;
`else
    sat = hi | lo;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else if (out_en) begin
      out_q <= clamped;
    end
  end

endmodule

// File: rtl/bias_add_requant.sv
// bias_add_requant
//   Adds the bias word to every PE output lane, requantises with a rounding
//   right shift, saturates to OUT_W bits and hands the result to the output
//   buffer writer. Tracks the beat count of a layer and pulses layer_done
//   once the last beat has left the pipeline.
//   Optional build macro: BIAS_ADD_RELU_EN (ReLU after saturation, inside
//   bias_lane_requant).
// Ports:
//   clk, rst          clock, async active-low reset
//   calculate_enble   start pulse; latches total_out and shift, flushes pipe
//   total_out         beats in this layer
//   shift             requant right-shift amount
//   pe_out_en         PE beat valid (same pulse that reads the bias buffer)
//   pe_data           LANES signed accumulators
//   bias_data         bias buffer data, valid BUF_LAT cycles after pe_out_en
//   out_valid         output beat valid (BUF_LAT+2 cycles after pe_out_en)
//   out_data          LANES requantised lanes, held when out_valid is low
//   busy              high in RUN and DRAIN
//   layer_done        one-cycle pulse after the last output beat
//   sat_flag          sticky: a lane saturated since start
//   err_flag          sticky: pe_out_en seen outside RUN
//
// state | meaning
// IDLE  | waiting for calculate_enble
// RUN   | accepting beats until total_out have been counted
// DRAIN | last beat accepted, waiting for the pipeline to empty
// DONE  | layer_done pulse, back to IDLE
module bias_add_requant
  import bias_add_requant_pkg::*;
#(
  parameter int LANES   = 8,
  parameter int ACC_W   = 32,
  parameter int BIAS_W  = 32,
  parameter int OUT_W   = 8,
  parameter int BUF_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    calculate_enble,
  input  logic [CNT_W-1:0]        total_out,
  input  logic [SHIFT_W-1:0]      shift,
  input  logic                    pe_out_en,
  input  logic [LANES*ACC_W-1:0]  pe_data,
  input  logic [LANES*BIAS_W-1:0] bias_data,
  output logic                    out_valid,
  output logic [LANES*OUT_W-1:0]  out_data,
  output logic                    busy,
  output logic                    layer_done,
  output logic                    sat_flag,
  output logic                    err_flag
);

  localparam int LANE_SUM_W = max_w(ACC_W, BIAS_W) + 1;

  state_t               state_q;
  state_t               state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     total_q;
  logic [SHIFT_W-1:0]   shift_q;
  logic [BUF_LAT-1:0]   align_v;
  logic [LANES*ACC_W-1:0] align_d [BUF_LAT];
  logic                 add_v;
  logic                 out_v;
  logic                 sat_q;
  logic                 err_q;
  logic                 beat_ok;
  logic                 out_load;
  logic [LANES-1:0]     lane_sat;

  // A start pulse wins over a beat in the same cycle; that beat is dropped.
  assign beat_ok  = pe_out_en && !calculate_enble && (state_q == RUN);
  assign out_load = add_v && !calculate_enble;

  always_comb begin
    state_d = state_q;
    if (calculate_enble) begin
      state_d = (total_out == '0) ? DONE : RUN;
    end else begin
      case (state_q)
        IDLE:  state_d = IDLE;
        RUN: begin
          if (pe_out_en && (cnt_q == total_q - CNT_W'(1))) begin
            state_d = DRAIN;
          end
        end
        // out_valid itself is not waited for: DONE then lands the cycle
        // after the final output beat.
        DRAIN: begin
          if ((align_v == '0) && !add_v) begin
            state_d = DONE;
          end
        end
        DONE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      total_q <= '0;
      shift_q <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (calculate_enble) begin
        cnt_q   <= '0;
        total_q <= total_out;
        shift_q <= shift;
        sat_q   <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        if (beat_ok) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        if (add_v && (|lane_sat)) begin
          sat_q <= 1'b1;
        end
        if (pe_out_en && (state_q != RUN)) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // Valid pipeline; a start pulse flushes every stage in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      align_v <= '0;
      add_v   <= 1'b0;
      out_v   <= 1'b0;
    end else if (calculate_enble) begin
      align_v <= '0;
      add_v   <= 1'b0;
      out_v   <= 1'b0;
    end else begin
      align_v[0] <= beat_ok;
      for (int i = 1; i < BUF_LAT; i++) begin
        align_v[i] <= align_v[i-1];
      end
      add_v <= align_v[BUF_LAT-1];
      out_v <= add_v;
    end
  end

  // Data side of the align delay line; qualified by align_v only.
  always_ff @(posedge clk) begin
    align_d[0] <= pe_data;
    for (int i = 1; i < BUF_LAT; i++) begin
      align_d[i] <= align_d[i-1];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    bias_lane_requant #(
      .ACC_W  (ACC_W),
      .BIAS_W (BIAS_W),
      .OUT_W  (OUT_W),
      .SUM_W  (LANE_SUM_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .add_en (align_v[BUF_LAT-1]),
      .out_en (out_load),
      .pe     (align_d[BUF_LAT-1][g*ACC_W +: ACC_W]),
      .bias   (bias_data[g*BIAS_W +: BIAS_W]),
      .shift  (shift_q),
      .out_q  (out_data[g*OUT_W +: OUT_W]),
      .sat    (lane_sat[g])
    );
  end

  assign out_valid  = out_v;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign layer_done = (state_q == DONE);
  assign sat_flag   = sat_q;
  assign err_flag   = err_q;

endmodule

// File: tb/tb_bias_add_requant.sv
// tb_bias_add_requant
//   Directed bench for bias_add_requant with default parameters. Every lane
//   carries the same value, so the full out_data word is checked against a
//   replicated expected byte. Honours BIAS_ADD_RELU_EN for the negative
//   saturation case.
module tb_bias_add_requant;

  localparam int LANES  = 8;
  localparam int ACC_W  = 32;
  localparam int BIAS_W = 32;
  localparam int OUT_W  = 8;
  localparam int CNT_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    calculate_enble = 1'b0;
  logic [CNT_W-1:0]        total_out = '0;
  logic [4:0]              shift = '0;
  logic                    pe_out_en = 1'b0;
  logic [LANES*ACC_W-1:0]  pe_data = '0;
  logic [LANES*BIAS_W-1:0] bias_data = '0;
  logic                    out_valid;
  logic [LANES*OUT_W-1:0]  out_data;
  logic                    busy;
  logic                    layer_done;
  logic                    sat_flag;
  logic                    err_flag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bias_add_requant #(
    .LANES(LANES), .ACC_W(ACC_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W),
    .BUF_LAT(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .calculate_enble(calculate_enble),
    .total_out(total_out), .shift(shift), .pe_out_en(pe_out_en),
    .pe_data(pe_data), .bias_data(bias_data), .out_valid(out_valid),
    .out_data(out_data), .busy(busy), .layer_done(layer_done),
    .sat_flag(sat_flag), .err_flag(err_flag)
  );

  function automatic logic [LANES*ACC_W-1:0] rep_acc(input int v);
    logic [LANES*ACC_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*ACC_W +: ACC_W] = v;
    return r;
  endfunction

  function automatic logic [LANES*OUT_W-1:0] rep_out(input logic [7:0] b);
    logic [LANES*OUT_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*OUT_W +: OUT_W] = b;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock: beat enable/data for this cycle and the bias answering the
  // previous cycle's beat (BUF_LAT = 1).
  task automatic tick(input logic en, input int pe_v, input int bias_v);
    pe_out_en = en;
    pe_data   = rep_acc(pe_v);
    bias_data = rep_acc(bias_v);
    step();
  endtask

  task automatic start_layer(input int tot, input int sh);
    calculate_enble = 1'b1;
    total_out       = tot[CNT_W-1:0];
    shift           = sh[4:0];
    pe_out_en       = 1'b0;
    step();
    calculate_enble = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    n_tests++;
    if ({out_valid, busy, layer_done, sat_flag, err_flag} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 00000", {out_valid, busy, layer_done, sat_flag, err_flag});
    end
    n_tests++;
    if (out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data got %h want 0", out_data);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_single_beat();
    start_layer(1, 2);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_run got %b want 1", busy); end
    tick(1'b1, 100, 0);
    tick(1'b0, 0, 28);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t1_early_valid got %b want 0", out_valid); end
    tick(1'b0, 0, 0);
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid got %b want 1", out_valid); end
    n_tests++;
    if (out_data !== rep_out(8'd32)) begin n_fail++; $display("FAIL t1_data got %h want %h", out_data, rep_out(8'd32)); end
    n_tests++;
    if (layer_done !== 1'b0) begin n_fail++; $display("FAIL t1_done_early got %b want 0", layer_done); end
    tick(1'b0, 0, 0);
    n_tests++;
    if ({layer_done, busy, out_valid} !== 3'b100) begin
      n_fail++; $display("FAIL t1_done got done/busy/valid %b want 100", {layer_done, busy, out_valid});
    end
    n_tests++;
    if (out_data !== rep_out(8'd32)) begin n_fail++; $display("FAIL t1_hold got %h want %h", out_data, rep_out(8'd32)); end
    tick(1'b0, 0, 0);
    n_tests++;
    if (layer_done !== 1'b0) begin n_fail++; $display("FAIL t1_done_pulse got %b want 0", layer_done); end
  endtask

  task automatic test_saturate();
    logic [7:0] exp_neg;
    logic       exp_sat;
`ifdef BIAS_ADD_RELU_EN
    exp_neg = 8'h00;
    exp_sat = 1'b0;
`else
    exp_neg = 8'h80;
    exp_sat = 1'b1;
`endif
    start_layer(1, 0);
    tick(1'b1, 1000, 0);
    tick(1'b0, 0, 0);
    tick(1'b0, 0, 0);
    n_tests++;
    if (out_data !== rep_out(8'h7F)) begin n_fail++; $display("FAIL t2_pos_sat got %h want %h", out_data, rep_out(8'h7F)); end
    n_tests++;
    if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL t2_pos_flag got %b want 1", sat_flag); end
    tick(1'b0, 0, 0);
    tick(1'b0, 0, 0);
    start_layer(1, 0);
    n_tests++;
    if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL t2_flag_clear got %b want 0", sat_flag); end
    tick(1'b1, -1000, 0);
    tick(1'b0, 0, 0);
    tick(1'b0, 0, 0);
    n_tests++;
    if (out_data !== rep_out(exp_neg)) begin n_fail++; $display("FAIL t2_neg_sat got %h want %h", out_data, rep_out(exp_neg)); end
    n_tests++;
    if (sat_flag !== exp_sat) begin n_fail++; $display("FAIL t2_neg_flag got %b want %b", sat_flag, exp_sat); end
    tick(1'b0, 0, 0);
    tick(1'b0, 0, 0);
  endtask

  task automatic test_rounding();
    start_layer(2, 1);
    tick(1'b1, -5, 0);
    tick(1'b1, 5, 0);
    tick(1'b0, 0, 0);
    n_tests++;
    if (out_data !== rep_out(8'hFE)) begin n_fail++; $display("FAIL t3_neg_round got %h want %h", out_data, rep_out(8'hFE)); end
    tick(1'b0, 0, 0);
    n_tests++;
    if ({out_valid, out_data} !== {1'b1, rep_out(8'h03)}) begin
      n_fail++; $display("FAIL t3_pos_round got %b/%h want 1/%h", out_valid, out_data, rep_out(8'h03));
    end
    tick(1'b0, 0, 0);
    tick(1'b0, 0, 0);
    start_layer(1, 31);
    tick(1'b1, 32'h7FFF_FFFF, 0);
    tick(1'b0, 0, 1);
    tick(1'b0, 0, 0);
    n_tests++;
    if (out_data !== rep_out(8'h01)) begin n_fail++; $display("FAIL t3_shift31 got %h want %h", out_data, rep_out(8'h01)); end
    n_tests++;
    if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL t3_no_sat got %b want 0", sat_flag); end
    tick(1'b0, 0, 0);
    tick(1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic en_v [8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int   pe_v [8]  = '{10, 20, 30, 40, 99, 0, 0, 0};
    int   bs_v [8]  = '{0, 1, 2, 3, 4, 0, 0, 0};
    logic exp_valid;
    logic [7:0] exp_byte;
    start_layer(4, 0);
    for (int k = 0; k < 8; k++) begin
      tick(en_v[k], pe_v[k], bs_v[k]);
      exp_valid = (k >= 2) && (k <= 5);
      exp_byte  = 8'(11 * (k - 1));
      n_tests++;
      if (out_valid !== exp_valid) begin
        n_fail++; $display("FAIL t4_valid[%0d] got %b want %b", k, out_valid, exp_valid);
      end
      if (exp_valid) begin
        n_tests++;
        if (out_data !== rep_out(exp_byte)) begin
          n_fail++; $display("FAIL t4_data[%0d] got %h want %h", k, out_data, rep_out(exp_byte));
        end
      end
      n_tests++;
      if (layer_done !== (k == 6)) begin
        n_fail++; $display("FAIL t4_done[%0d] got %b want %b", k, layer_done, (k == 6));
      end
      n_tests++;
      if (busy !== (k <= 5)) begin
        n_fail++; $display("FAIL t4_busy[%0d] got %b want %b", k, busy, (k <= 5));
      end
    end
    n_tests++;
    if (err_flag !== 1'b1) begin n_fail++; $display("FAIL t4_err got %b want 1", err_flag); end
  endtask

  task automatic test_zero_layer();
    start_layer(0, 3);
    n_tests++;
    if ({layer_done, busy, out_valid, err_flag} !== 4'b1000) begin
      n_fail++; $display("FAIL t5_done got done/busy/valid/err %b want 1000", {layer_done, busy, out_valid, err_flag});
    end
    tick(1'b0, 0, 0);
    n_tests++;
    if ({layer_done, out_valid} !== 2'b00) begin
      n_fail++; $display("FAIL t5_after got done/valid %b want 00", {layer_done, out_valid});
    end
  endtask

  task automatic test_restart();
    start_layer(4, 0);
    tick(1'b1, 7, 0);
    tick(1'b1, 8, 0);
    calculate_enble = 1'b1;
    total_out       = 16'd1;
    shift           = 5'd0;
    pe_out_en       = 1'b1;
    pe_data         = rep_acc(9);
    bias_data       = rep_acc(0);
    step();
    calculate_enble = 1'b0;
    n_tests++;
    if ({out_valid, busy, err_flag} !== 3'b010) begin
      n_fail++; $display("FAIL t6_flush got valid/busy/err %b want 010", {out_valid, busy, err_flag});
    end
    tick(1'b1, 50, 0);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t6_inflight got %b want 0", out_valid); end
    tick(1'b0, 0, 5);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t6_gap got %b want 0", out_valid); end
    tick(1'b0, 0, 0);
    n_tests++;
    if ({out_valid, out_data} !== {1'b1, rep_out(8'd55)}) begin
      n_fail++; $display("FAIL t6_new_data got %b/%h want 1/%h", out_valid, out_data, rep_out(8'd55));
    end
    tick(1'b0, 0, 0);
    n_tests++;
    if (layer_done !== 1'b1) begin n_fail++; $display("FAIL t6_done got %b want 1", layer_done); end
    tick(1'b0, 0, 0);
  endtask

  task automatic test_async_reset();
    start_layer(2, 0);
    tick(1'b1, 1, 0);
    pe_out_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, busy, layer_done, sat_flag, err_flag} !== 5'b0) begin
      n_fail++; $display("FAIL t7_rst_flags got %b want 00000", {out_valid, busy, layer_done, sat_flag, err_flag});
    end
    n_tests++;
    if (out_data !== '0) begin n_fail++; $display("FAIL t7_rst_data got %h want 0", out_data); end
    step();
    rst = 1'b1;
    step();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL t7_idle got busy %b want 0", busy); end
    tick(1'b1, 3, 0);
    pe_out_en = 1'b0;
    n_tests++;
    if (err_flag !== 1'b1) begin n_fail++; $display("FAIL t7_idle_err got %b want 1", err_flag); end
  endtask

  initial begin
    test_reset();
    n_tests++;
    if (err_flag !== 1'b0) begin n_fail++; $display("FAIL err_initial got %b want 0", err_flag); end
    test_single_beat();
    test_saturate();
    test_rounding();
    test_back_to_back();
    test_zero_layer();
    test_restart();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
